// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the bypassing register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per entry, set on issue and cleared on writeback.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run_i,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  output logic [(2**ADDR_W)-1:0]   busy_o,
  output logic                     alloc_conflict_o
);

  logic [(2**ADDR_W)-1:0] busy_q, busy_d;
  logic                   conflict_q, conflict_d;
  logic                   alloc_v, wr_v;

  always_comb begin
    alloc_v = run_i & alloc_en_i & ~((ZERO_REG != 0) && (alloc_addr_i == '0));
    wr_v    = run_i & wr_en_i;
    busy_d  = busy_q;
    // The set is applied last so a same-cycle allocation beats the writeback.
    if (wr_v)    busy_d[wr_addr_i]    = 1'b0;
    if (alloc_v) busy_d[alloc_addr_i] = 1'b1;
    conflict_d = alloc_v & busy_q[alloc_addr_i] & ~(wr_v & (wr_addr_i == alloc_addr_i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_o           = busy_q;
  assign alloc_conflict_o = conflict_q;

endmodule

// File: rtl/reg_file_bypass.sv
// Multi-read, single-write register file with write-first bypass and an issue scoreboard.
// state | meaning
// CLEAR | zeroing one entry per cycle, accesses ignored
// RUN   | normal operation, ready high
module reg_file_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_conflict
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic                run, clr_we, wr_ok;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [ADDR_W-1:0]   ra [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == CLEAR) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (clear_ptr_q == LAST_PTR) state_d = RUN;
    end
  end

  always_comb begin
    run    = (state_q == RUN);
    clr_we = (state_q == CLEAR);
    ready  = run;
  end

  assign wr_ok = run & wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));

  // Storage is not reset; the clear sequence initialises it after every reset.
  always_ff @(posedge clk) begin
    if (clr_we)     mem_q[clear_ptr_q] <= '0;
    else if (wr_ok) mem_q[wr_addr]     <= wr_data;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (run && rd_en[i]) begin
        if ((ZERO_REG != 0) && (ra[i] == '0)) begin
          rd_data_d[i*DATA_W +: DATA_W] = '0;
          rd_busy_d[i]                  = 1'b0;
        end else if (wr_en && (wr_addr == ra[i])) begin
          rd_data_d[i*DATA_W +: DATA_W] = wr_data;
          rd_busy_d[i]                  = 1'b0;
        end else begin
          rd_data_d[i*DATA_W +: DATA_W] = mem_q[ra[i]];
          rd_busy_d[i]                  = busy[ra[i]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (run),
    .alloc_en_i       (alloc_en),
    .alloc_addr_i     (alloc_addr),
    .wr_en_i          (wr_en),
    .wr_addr_i        (wr_addr),
    .busy_o           (busy),
    .alloc_conflict_o (alloc_conflict)
  );

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed plus randomized checks of reg_file_bypass against a behavioural register-file model.
module tb_reg_file_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_conflict;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy = '0;
  logic [31:0] m_rd [2];
  logic [1:0]  m_rdb = '0;
  logic        m_conf = 1'b0;
  logic        m_ready = 1'b0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  reg_file_bypass dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ready          (ready),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_busy        (rd_busy),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .alloc_en       (alloc_en),
    .alloc_addr     (alloc_addr),
    .alloc_conflict (alloc_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour applied at each rising edge using the inputs currently driven.
  task automatic model_step();
    logic [4:0] a;
    if (!rst_n) begin
      m_cnt = 0; m_ready = 1'b0; m_busy = '0; m_rdb = '0; m_conf = 1'b0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else if (!m_ready) begin
      m_conf = 1'b0;
      m_cnt++;
      if (m_cnt == 32) begin
        m_ready = 1'b1;
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          a = rd_addr[p*5 +: 5];
          if (a == 0) begin
            m_rd[p] = '0; m_rdb[p] = 1'b0;
          end else if (wr_en && wr_addr == a) begin
            m_rd[p] = wr_data; m_rdb[p] = 1'b0;
          end else begin
            m_rd[p] = m_mem[a]; m_rdb[p] = m_busy[a];
          end
        end
      end
      m_conf = alloc_en && (alloc_addr != 0) && m_busy[alloc_addr] &&
               !(wr_en && wr_addr == alloc_addr);
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_data[%0d]", p), rd_data[p*32 +: 32], m_rd[p]);
      chk($sformatf("rd_busy[%0d]", p), {31'd0, rd_busy[p]}, {31'd0, m_rdb[p]});
    end
    chk("alloc_conflict", {31'd0, alloc_conflict}, {31'd0, m_conf});
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic rnd_inputs(input int amax);
    rd_en      = 2'($urandom_range(0, 3));
    rd_addr    = {5'($urandom_range(0, amax)), 5'($urandom_range(0, amax))};
    wr_en      = 1'($urandom_range(0, 1));
    wr_addr    = 5'($urandom_range(0, amax));
    wr_data    = $urandom;
    alloc_en   = 1'($urandom_range(0, 1));
    alloc_addr = 5'($urandom_range(0, amax));
  endtask

  // Counts cycles until ready while hammering the inputs, which must be ignored.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      rnd_inputs(31);
      cycle();
      n++;
    end
    idle();
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    wait_ready("clear_len");

    for (int a = 0; a < 32; a += 2) begin
      rd_en = 2'b11; rd_addr = {5'(a + 1), 5'(a)};
      cycle();
    end

    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    cycle();
    chk("bypass_r7", rd_data[31:0], 32'hDEADBEEF);

    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    cycle();
    idle();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    cycle();
    chk("zero_reg_p0", rd_data[31:0], 32'd0);
    chk("zero_reg_p1", rd_data[63:32], 32'd0);
    chk("zero_busy", {30'd0, rd_busy}, 32'd0);

    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    cycle();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    cycle();
    chk("busy_r3", {31'd0, rd_busy[0]}, 32'd1);
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    cycle();
    chk("conflict_r3", {31'd0, alloc_conflict}, 32'd1);
    idle();
    cycle();
    chk("conflict_pulse", {31'd0, alloc_conflict}, 32'd0);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_0003;
    cycle();
    idle();
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    cycle();
    chk("busy_r3_clr", {31'd0, rd_busy[1]}, 32'd0);
    chk("data_r3", rd_data[63:32], 32'hA5A5_0003);

    idle();
    alloc_en = 1'b1; alloc_addr = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    cycle();
    chk("no_conflict_r5", {31'd0, alloc_conflict}, 32'd0);
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    cycle();
    chk("busy_r5", {31'd0, rd_busy[0]}, 32'd1);

    for (int k = 0; k < 400; k++) begin
      rnd_inputs((k % 4 == 0) ? 31 : 7);
      cycle();
    end

    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wait_ready("reclear_len");
    for (int k = 0; k < 60; k++) begin
      rnd_inputs(7);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
